// File: rtl/skid_buffer.sv
// Two-entry registered skid buffer for the data-cache ACP request port; busy_o is the skid-full flag.
// Define SKID_BUFFER_DATA_RESET_EN to reset and flush the payload registers to zero.
module skid_buffer #(
   parameter int WIDTH = 32
) (
   input  logic             cpu_clock_i,
   input  logic             cpu_resetn_i,
   input  logic             flush_i,
   input  logic             busy_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             busy_o,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i
);

   logic             out_v_r;
   logic             skid_v_r;
   logic [WIDTH-1:0] out_d_r;
   logic [WIDTH-1:0] skid_d_r;
   logic             acc_s;
   logic             drn_s;

   // Accept and drain qualifiers, all from registered state plus handshake inputs
   always_comb begin
      acc_s = valid_i & ~skid_v_r;
      drn_s = out_v_r & ~busy_i;
   end

   // Valid flags: flush, skid move, skid hold, output load, skid load, hold
   always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
      if (!cpu_resetn_i) begin
         out_v_r  <= 1'b0;
         skid_v_r <= 1'b0;
      end else if (flush_i) begin
         out_v_r  <= 1'b0;
         skid_v_r <= 1'b0;
      end else if (skid_v_r) begin
         if (!busy_i) begin
            out_v_r  <= 1'b1;
            skid_v_r <= 1'b0;
         end else begin
            out_v_r  <= out_v_r;
            skid_v_r <= skid_v_r;
         end
      end else if (!out_v_r || drn_s) begin
         out_v_r <= acc_s;
      end else if (acc_s) begin
         skid_v_r <= 1'b1;
      end else begin
         out_v_r  <= out_v_r;
         skid_v_r <= skid_v_r;
      end
   end

`ifdef SKID_BUFFER_DATA_RESET_EN
   // Payload registers with async reset and synchronous clear on flush
   always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
      if (!cpu_resetn_i) begin
         out_d_r  <= {WIDTH{1'b0}};
         skid_d_r <= {WIDTH{1'b0}};
      end else if (flush_i) begin
         out_d_r  <= {WIDTH{1'b0}};
         skid_d_r <= {WIDTH{1'b0}};
      end else if (skid_v_r) begin
         if (!busy_i) begin
            out_d_r <= skid_d_r;
         end else begin
            out_d_r <= out_d_r;
         end
      end else if (!out_v_r || drn_s) begin
         if (acc_s) begin
            out_d_r <= data_i;
         end else begin
            out_d_r <= out_d_r;
         end
      end else if (acc_s) begin
         skid_d_r <= data_i;
      end else begin
         skid_d_r <= skid_d_r;
      end
   end
`else
   // Payload registers without reset; only the valid flags qualify their contents
   always_ff @(posedge cpu_clock_i) begin
      if (skid_v_r) begin
         if (!busy_i) begin
            out_d_r <= skid_d_r;
         end else begin
            out_d_r <= out_d_r;
         end
      end else if (!out_v_r || drn_s) begin
         if (acc_s) begin
            out_d_r <= data_i;
         end else begin
            out_d_r <= out_d_r;
         end
      end else if (acc_s) begin
         skid_d_r <= data_i;
      end else begin
         skid_d_r <= skid_d_r;
      end
   end
`endif

   assign data_o  = out_d_r;
   assign valid_o = out_v_r;
   assign busy_o  = skid_v_r;

`ifndef SYNTHESIS
   skid_buffer_chk #(.WIDTH(WIDTH)) u_chk (
      .clk     (cpu_clock_i),
      .rst_n   (cpu_resetn_i),
      .flush   (flush_i),
      .busy    (busy_i),
      .out_v   (out_v_r),
      .skid_v  (skid_v_r),
      .data    (out_d_r)
   );
`endif

endmodule

`ifndef SYNTHESIS
// Protocol checker: skid entry only behind a valid output, output payload held under backpressure.
module skid_buffer_chk #(
   parameter int WIDTH = 32
) (
   input logic             clk,
   input logic             rst_n,
   input logic             flush,
   input logic             busy,
   input logic             out_v,
   input logic             skid_v,
   input logic [WIDTH-1:0] data
);

   a_skid_implies_out: assert property (@(posedge clk) disable iff (!rst_n)
      skid_v |-> out_v);

   a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_v && busy && !flush) |=> $stable(data));

endmodule
`endif

// File: tb/tb_skid_buffer.sv
// Directed scoreboard bench for skid_buffer: stimulus pushes accepted words, a negedge monitor pops on each transfer.
// Honours SKID_BUFFER_DATA_RESET_EN for the zeroed-payload checks.
module tb_skid_buffer;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             busy_in;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic             busy_out;
   logic [WIDTH-1:0] data_in;
   logic             valid_in;

   logic [WIDTH-1:0] exp_q[$];
   int               n_checks = 0;
   int               n_pass   = 0;

   skid_buffer #(.WIDTH(WIDTH)) dut (
      .cpu_clock_i  (clk),
      .cpu_resetn_i (rst_n),
      .flush_i      (flush),
      .busy_i       (busy_in),
      .data_o       (data_out),
      .valid_o      (valid_out),
      .busy_o       (busy_out),
      .data_i       (data_in),
      .valid_i      (valid_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // A transfer happens on the next rising edge whenever valid_o & !busy_i here
   always @(negedge clk) begin
      if (rst_n && valid_out && !busy_in) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL monitor_unexpected: got %h, expected no output at %0t", data_out, $time);
         end else begin
            chk("monitor_data", data_out, exp_q.pop_front());
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      flush    = 1'b0;
      busy_in  = 1'b0;
      valid_in = 1'b0;
      data_in  = 32'h0;

      // Reset then idle
      step();
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_valid", {31'b0, valid_out}, 32'h0);
      chk("reset_busy", {31'b0, busy_out}, 32'h0);
`ifdef SKID_BUFFER_DATA_RESET_EN
      chk("reset_data", data_out, 32'h0);
`endif

      // Streaming with no backpressure
      step();
      valid_in = 1'b1;
      data_in  = 32'h11; exp_q.push_back(32'h11);
      step();
      data_in  = 32'h22; exp_q.push_back(32'h22);
      @(negedge clk);
      chk("stream_valid_1", {31'b0, valid_out}, 32'h1);
      chk("stream_busy_1", {31'b0, busy_out}, 32'h0);
      step();
      data_in  = 32'h33; exp_q.push_back(32'h33);
      @(negedge clk);
      chk("stream_busy_2", {31'b0, busy_out}, 32'h0);
      step();
      valid_in = 1'b0;
      @(negedge clk);
      chk("stream_valid_3", {31'b0, valid_out}, 32'h1);
      chk("stream_busy_3", {31'b0, busy_out}, 32'h0);
      step();
      @(negedge clk);
      chk("stream_empty", {31'b0, valid_out}, 32'h0);

      // Backpressure fill
      busy_in  = 1'b1;
      valid_in = 1'b1;
      data_in  = 32'hA1; exp_q.push_back(32'hA1);
      step();
      data_in  = 32'hA2; exp_q.push_back(32'hA2);
      @(negedge clk);
      chk("fill_valid", {31'b0, valid_out}, 32'h1);
      chk("fill_data", data_out, 32'hA1);
      chk("fill_busy_pre", {31'b0, busy_out}, 32'h0);
      step();
      data_in  = 32'hA3; exp_q.push_back(32'hA3);
      @(negedge clk);
      chk("full_busy", {31'b0, busy_out}, 32'h1);
      step();
      @(negedge clk);
      chk("full_hold_busy", {31'b0, busy_out}, 32'h1);
      chk("full_hold_data", data_out, 32'hA1);

      // Drain: A1, A2, then A3 once busy_o drops
      busy_in = 1'b0;
      step();
      @(negedge clk);
      chk("drain_busy_low", {31'b0, busy_out}, 32'h0);
      chk("drain_data_a2", data_out, 32'hA2);
      step();
      valid_in = 1'b0;
      @(negedge clk);
      chk("drain_data_a3", data_out, 32'hA3);
      step();
      step();
      @(negedge clk);
      chk("drain_empty", {31'b0, valid_out}, 32'h0);

      // Flush from full with a simultaneous offer
      busy_in  = 1'b1;
      valid_in = 1'b1;
      data_in  = 32'hB1;
      step();
      data_in  = 32'hB2;
      step();
      valid_in = 1'b0;
      @(negedge clk);
      chk("preflush_busy", {31'b0, busy_out}, 32'h1);
      step();
      flush    = 1'b1;
      valid_in = 1'b1;
      data_in  = 32'hFF;
      step();
      flush    = 1'b0;
      valid_in = 1'b0;
      busy_in  = 1'b0;
      @(negedge clk);
      chk("flush_valid", {31'b0, valid_out}, 32'h0);
      chk("flush_busy", {31'b0, busy_out}, 32'h0);
`ifdef SKID_BUFFER_DATA_RESET_EN
      chk("flush_data", data_out, 32'h0);
`endif
      step();
      step();

      // Async reset while full
      busy_in  = 1'b1;
      valid_in = 1'b1;
      data_in  = 32'hC1;
      step();
      data_in  = 32'hC2;
      step();
      valid_in = 1'b0;
      @(negedge clk);
      chk("prereset_busy", {31'b0, busy_out}, 32'h1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_valid", {31'b0, valid_out}, 32'h0);
      chk("async_busy", {31'b0, busy_out}, 32'h0);
      busy_in = 1'b0;
      step();
      step();
      rst_n = 1'b1;

      // Recovery after reset
      step();
      valid_in = 1'b1;
      data_in  = 32'h5A; exp_q.push_back(32'h5A);
      step();
      valid_in = 1'b0;
      @(negedge clk);
      chk("recover_valid", {31'b0, valid_out}, 32'h1);
      step();
      step();
      chk("scoreboard_drained", exp_q.size(), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
